// File: rtl/col_norm_sq_accum.sv
// Sum-of-squares accumulator feeding the Sqrt CORDIC: streams one Q7.8 column,
// launches the square-root unit with the Q24.8 sum and waits for its stop flag.
module col_norm_sq_accum #(
  parameter int unsigned N_MAX  = 16,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              sqrt_start,
  output logic [31:0]       sqrt_in,
  input  logic              sqrt_done,
  output logic              col_done,
  output logic [4:0]        col_len,
  output logic              len_err
);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_LAUNCH, S_WAIT} state_t;

  state_t state, state_nx;

  logic [31:0]              acc;
  logic [4:0]               cnt;
  logic                     guard;
  logic signed [2*DATA_W-1:0] prod;
  logic [31:0]              sq;
  logic [31:0]              acc_nx;
  logic [4:0]               cnt_nx;
  logic                     xfer;
  logic                     hit;
  logic                     close;
  logic                     forced;

  assign prod   = $signed(in_data) * $signed(in_data);
  assign sq     = 32'(prod) >> 8;
  assign xfer   = in_valid && in_ready;
  assign acc_nx = (state == S_IDLE) ? sq : acc + sq;
  assign cnt_nx = (state == S_IDLE) ? 5'd1 : cnt + 5'd1;
  assign hit    = (cnt_nx == 5'(N_MAX));
  assign close  = xfer && (in_last || hit);
  // in_last on the boundary element ends the column normally
  assign forced = xfer && hit && !in_last && (state == S_ACCUM);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= S_IDLE;
      acc        <= '0;
      cnt        <= '0;
      guard      <= 1'b0;
      sqrt_in    <= '0;
      col_len    <= '0;
      len_err    <= 1'b0;
      col_done   <= 1'b0;
    end else begin
      state    <= state_nx;
      col_done <= (state == S_WAIT) && !guard && sqrt_done;
      if (xfer) begin
        acc <= acc_nx;
        cnt <= cnt_nx;
      end
      if (xfer && state == S_IDLE)
        len_err <= 1'b0;
      if (forced)
        len_err <= 1'b1;
      // Publish at the closing edge so sqrt_in is already stable during sqrt_start
      if (close) begin
        sqrt_in <= acc_nx;
        col_len <= cnt_nx;
      end
      if (state == S_LAUNCH)
        guard <= 1'b1;
      else if (state == S_WAIT)
        guard <= 1'b0;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: begin
        if (close)     state_nx = S_LAUNCH;
        else if (xfer) state_nx = S_ACCUM;
      end
      S_ACCUM: begin
        if (close) state_nx = S_LAUNCH;
      end
      S_LAUNCH: state_nx = S_WAIT;
      S_WAIT: begin
        // first WAIT cycle still sees the previous run's stop flag
        if (!guard && sqrt_done) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready   = 1'b0;
    sqrt_start = 1'b0;
    unique case (state)
      S_IDLE, S_ACCUM: in_ready = rst;
      S_LAUNCH:        sqrt_start = 1'b1;
      default: ;
    endcase
  end

endmodule
